// File: rtl/systolic_result_drain.sv
// ---------------------------------------------------------------------------
// systolic_result_drain
//   Walks the systolic array's result mux over every (row, col) index and
//   streams the selected words out one element per val/rdy transaction.
//   A one-entry output register reloads on fire, so a consumer that holds
//   send_rdy high sees one element per cycle.
//
// Build option:
//   SYSTOLIC_DRAIN_CMO_EN  defined   -> column-major walk (row index first)
//                          undefined -> row-major walk (column index first)
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-low reset
//   start_val  in   request to drain the current result matrix
//   start_rdy  out  high only while idle
//   out_rsel   out  row select to the array result mux
//   out_csel   out  column select to the array result mux
//   b_s_in     in   selected array result (combinational from the selects)
//   send_msg   out  serialized result element
//   send_val   out  send_msg valid
//   send_rdy   in   consumer ready
//   busy       out  high while fetching or draining
//   done       out  one-cycle pulse after the last element transfers
// ---------------------------------------------------------------------------
module systolic_result_drain #(
   parameter int unsigned size  = 4,
   parameter int unsigned nbits = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start_val,
   output logic                     start_rdy,
   output logic [$clog2(size)-1:0]  out_rsel,
   output logic [$clog2(size)-1:0]  out_csel,
   input  logic [nbits-1:0]         b_s_in,
   output logic [nbits-1:0]         send_msg,
   output logic                     send_val,
   input  logic                     send_rdy,
   output logic                     busy,
   output logic                     done
);

   localparam int unsigned sel_w = $clog2(size);
   localparam logic [sel_w-1:0] idx_max = sel_w'(size - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t           state;
   logic [sel_w-1:0] row;
   logic [sel_w-1:0] col;

   logic             fire_c;
   logic             load_c;
   logic             last_idx_c;
   logic [sel_w-1:0] row_nxt_c;
   logic [sel_w-1:0] col_nxt_c;

   // The index registers drive the array selects directly.
   assign out_rsel = row;
   assign out_csel = col;

   // Transfer / capture qualifiers and the next index in walk order.
   always_comb begin
      fire_c     = send_val & send_rdy;
      load_c     = (state == FETCH) & (~send_val | fire_c);
      last_idx_c = (row == idx_max) & (col == idx_max);
`ifdef SYSTOLIC_DRAIN_CMO_EN
      row_nxt_c  = (row == idx_max) ? '0 : row + sel_w'(1);
      col_nxt_c  = col;
      if (row == idx_max) begin
         col_nxt_c = (col == idx_max) ? '0 : col + sel_w'(1);
      end
`else
      col_nxt_c  = (col == idx_max) ? '0 : col + sel_w'(1);
      row_nxt_c  = row;
      if (col == idx_max) begin
         row_nxt_c = (row == idx_max) ? '0 : row + sel_w'(1);
      end
`endif
   end

   // Controller: state, index walk, output register and status flags.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         row       <= '0;
         col       <= '0;
         send_msg  <= '0;
         send_val  <= 1'b0;
         start_rdy <= 1'b1;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start_val) begin
                  state     <= FETCH;
                  row       <= '0;
                  col       <= '0;
                  start_rdy <= 1'b0;
                  busy      <= 1'b1;
               end
            end
            FETCH: begin
               if (load_c) begin
                  send_msg <= b_s_in;
                  send_val <= 1'b1;
                  row      <= row_nxt_c;
                  col      <= col_nxt_c;
                  if (last_idx_c) begin
                     state <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               // Last element leaves: report completion and reopen for starts.
               if (fire_c) begin
                  send_val  <= 1'b0;
                  done      <= 1'b1;
                  busy      <= 1'b0;
                  start_rdy <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
